// File: rtl/scanned_display_driver_if.sv
// scanned_display_driver_if: binary value and blanking controls in, scanned 7-segment drive and status out
interface scanned_display_driver_if #(parameter int BIN_WIDTH = 16);
   logic [BIN_WIDTH-1:0] value;
   logic                 blank_lz;
   logic                 blank;
   logic [7:0]           AN;
   logic [6:0]           seg;
   logic                 busy;
   logic                 done;
   modport master (output value, blank_lz, blank, input AN, seg, busy, done);
   modport slave (input value, blank_lz, blank, output AN, seg, busy, done);
endinterface

// File: rtl/scanned_display_driver.sv
// scanned_display_driver: double-dabble binary to BCD conversion feeding a multiplexed
// active-low 7-segment display with leading-zero blanking and overflow dashes
module scanned_display_driver #(
   parameter int NUM_DIGITS = 5,
   parameter int BIN_WIDTH  = 16,
   parameter int SCAN_DIV   = 1000
) (
   input logic clk,
   input logic reset,
   scanned_display_driver_if.slave bus
);
   // at least one nibble above the displayed digits so overflow is a simple OR
   localparam int BCD_MIN = BIN_WIDTH * 301 / 1000 + 1;
   localparam int BCD_DIG = BCD_MIN > NUM_DIGITS ? BCD_MIN : NUM_DIGITS + 1;
   localparam int BCD_W   = 4 * BCD_DIG;
   localparam int CW      = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   typedef enum logic [1:0] {IDLE, CONVERT, LATCH} state_t;
   state_t                        r_state, w_next;
   logic [BCD_W+BIN_WIDTH-1:0]    r_sh, w_step;
   logic [BIN_WIDTH-1:0]          r_last;
   logic                          r_pend, r_ovf, r_done;
   logic [4:0]                    r_cnt;
   logic [NUM_DIGITS-1:0][3:0]    r_disp;
   logic [CW-1:0]                 r_scan;
   logic [2:0]                    r_dig;
   logic [7:0]                    r_an;
   logic [6:0]                    r_seg, w_seg;
   logic [3:0]                    w_nib;
   logic                          w_zero, w_lzb, w_start;
   assign w_start  = (bus.value != r_last) || r_pend;
   assign bus.AN   = r_an;
   assign bus.seg  = r_seg;
   assign bus.busy = r_state != IDLE;
   assign bus.done = r_done;
   always_comb begin
      w_next = r_state;
      w_next = (r_state == IDLE) ? (w_start ? CONVERT : IDLE) :
               (r_state == CONVERT) ? (r_cnt == 5'(BIN_WIDTH - 1) ? LATCH : CONVERT) : IDLE;
   end
   always_comb begin
      w_step = r_sh;
      for (int i = 0; i < BCD_DIG; i++)
         if (w_step[BIN_WIDTH+4*i +: 4] >= 4'd5) w_step[BIN_WIDTH+4*i +: 4] = w_step[BIN_WIDTH+4*i +: 4] + 4'd3;
      w_step = w_step << 1;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) r_state <= IDLE;
      else r_state <= w_next;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sh   <= '0;
         r_last <= '0;
         r_pend <= 1'b1;
         r_cnt  <= '0;
         r_disp <= '0;
         r_ovf  <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= r_state == LATCH;
         if (r_state == IDLE && w_start) begin
            r_sh   <= {{BCD_W{1'b0}}, bus.value};
            r_last <= bus.value;
            r_pend <= 1'b0;
            r_cnt  <= '0;
         end else if (r_state == CONVERT) begin
            r_sh  <= w_step;
            r_cnt <= r_cnt + 5'd1;
         end else if (r_state == LATCH) begin
            r_disp <= r_sh[BIN_WIDTH +: 4*NUM_DIGITS];
            r_ovf  <= |r_sh[BIN_WIDTH+4*NUM_DIGITS +: BCD_W-4*NUM_DIGITS];
         end
      end
   end
   // w_zero accumulates "this digit and every higher one is zero" from the top down
   always_comb begin
      w_nib  = 4'd0;
      w_lzb  = 1'b0;
      w_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         w_zero = w_zero & (r_disp[i] == 4'd0);
         if (r_dig == 3'(i)) begin
            w_nib = r_disp[i];
            w_lzb = w_zero && (i != 0);
         end
      end
      case (w_nib)
         4'd0:    w_seg = 7'h40;
         4'd1:    w_seg = 7'h79;
         4'd2:    w_seg = 7'h24;
         4'd3:    w_seg = 7'h30;
         4'd4:    w_seg = 7'h19;
         4'd5:    w_seg = 7'h12;
         4'd6:    w_seg = 7'h02;
         4'd7:    w_seg = 7'h78;
         4'd8:    w_seg = 7'h00;
         4'd9:    w_seg = 7'h10;
         default: w_seg = 7'h7F;
      endcase
      w_seg = r_ovf ? 7'h3F : (bus.blank_lz && w_lzb) ? 7'h7F : w_seg;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_scan <= '0;
         r_dig  <= '0;
         r_an   <= 8'hFF;
         r_seg  <= 7'h7F;
      end else begin
         r_scan <= r_scan == CW'(SCAN_DIV - 1) ? '0 : r_scan + 1'b1;
         if (r_scan == CW'(SCAN_DIV - 1)) r_dig <= r_dig == 3'(NUM_DIGITS - 1) ? 3'd0 : r_dig + 3'd1;
         r_an   <= bus.blank ? 8'hFF : ~(8'd1 << r_dig);
         r_seg  <= w_seg;
      end
   end
endmodule
